// File: rtl/mili_pkg.sv
// rtl/mili_pkg.sv - shared state encoding, wrap constants and field widths
package mili_pkg;

  localparam int MIN_W = 7;
  localparam int SEC_W = 6;
  localparam int MS_W  = 10;

  localparam logic [MS_W-1:0]  MS_WRAP  = 10'd999;
  localparam logic [SEC_W-1:0] SEC_WRAP = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

endpackage

// File: rtl/mili_tick_sync.sv
// rtl/mili_tick_sync.sv - usr_clk synchroniser and edge detect producing a one-cycle tick
module mili_tick_sync #(
  parameter int BOTH_EDGES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic usr_clk,
  output logic tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= usr_clk;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign tick = (BOTH_EDGES != 0) ? (r_sync2 ^ r_prev) : (r_sync2 & ~r_prev);

endmodule

// File: rtl/mili_stopwatch.sv
// rtl/mili_stopwatch.sv - min:sec:ms stopwatch with lap freeze and overflow saturation
module mili_stopwatch
  import mili_pkg::*;
#(
  parameter int BOTH_EDGES = 1,
  parameter int MIN_MAX    = 99
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             usr_clk,
  input  logic             start_stop,
  input  logic             lap_clear,
  output logic [MIN_W-1:0] disp_min,
  output logic [SEC_W-1:0] disp_sec,
  output logic [MS_W-1:0]  disp_ms,
  output logic             running,
  output logic             lap_active,
  output logic             overflow
);

  state_t             r_state;
  state_t             w_state_n;
  logic [MIN_W-1:0]   r_min, w_min_n, r_disp_min;
  logic [SEC_W-1:0]   r_sec, w_sec_n, r_disp_sec;
  logic [MS_W-1:0]    r_ms,  w_ms_n,  r_disp_ms;
  logic               r_ovf;
  logic               w_tick;
  logic               w_count_en;
  logic               w_at_max;
  logic               w_sat;
  logic               w_clear;

  mili_tick_sync #(.BOTH_EDGES(BOTH_EDGES)) u_tick_sync (
    .clk     (clk),
    .reset   (reset),
    .usr_clk (usr_clk),
    .tick    (w_tick)
  );

  assign w_count_en = w_tick && ((r_state == RUN) || (r_state == LAP));
  assign w_at_max   = (r_min == MIN_W'(MIN_MAX)) && (r_sec == SEC_WRAP) && (r_ms == MS_WRAP);
  assign w_sat      = w_count_en && w_at_max;
  assign w_clear    = (r_state == PAUSE) && !start_stop && lap_clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // start_stop is tested first in every state so it wins over lap_clear
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: begin
        if (start_stop && !r_ovf) w_state_n = RUN;
      end
      RUN: begin
        if (start_stop)     w_state_n = PAUSE;
        else if (lap_clear) w_state_n = LAP;
      end
      LAP: begin
        if (start_stop)     w_state_n = PAUSE;
        else if (lap_clear) w_state_n = RUN;
      end
      PAUSE: begin
        if (start_stop)     w_state_n = r_ovf ? PAUSE : RUN;
        else if (lap_clear) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    if (w_sat) w_state_n = PAUSE;
  end

  always_comb begin
    w_min_n = r_min;
    w_sec_n = r_sec;
    w_ms_n  = r_ms;
    if (w_clear) begin
      w_min_n = '0;
      w_sec_n = '0;
      w_ms_n  = '0;
    end else if (w_count_en && !w_at_max) begin
      if (r_ms == MS_WRAP) begin
        w_ms_n = '0;
        if (r_sec == SEC_WRAP) begin
          w_sec_n = '0;
          w_min_n = r_min + 1'b1;
        end else begin
          w_sec_n = r_sec + 1'b1;
        end
      end else begin
        w_ms_n = r_ms + 1'b1;
      end
    end
  end

  // Display follows the next count except while remaining in LAP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_min      <= '0;
      r_sec      <= '0;
      r_ms       <= '0;
      r_ovf      <= 1'b0;
      r_disp_min <= '0;
      r_disp_sec <= '0;
      r_disp_ms  <= '0;
    end else begin
      r_min <= w_min_n;
      r_sec <= w_sec_n;
      r_ms  <= w_ms_n;
      if (w_clear)    r_ovf <= 1'b0;
      else if (w_sat) r_ovf <= 1'b1;
      if ((r_state != LAP) || (w_state_n != LAP)) begin
        r_disp_min <= w_min_n;
        r_disp_sec <= w_sec_n;
        r_disp_ms  <= w_ms_n;
      end
    end
  end

  assign disp_min   = r_disp_min;
  assign disp_sec   = r_disp_sec;
  assign disp_ms    = r_disp_ms;
  assign running    = (r_state == RUN) || (r_state == LAP);
  assign lap_active = (r_state == LAP);
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_mili_stopwatch.sv
// tb/tb_mili_stopwatch.sv - directed table-driven bench for mili_stopwatch
module tb_mili_stopwatch;

  localparam int OP_TICKS = 0;
  localparam int OP_SS    = 1;
  localparam int OP_LC    = 2;
  localparam int OP_BOTH  = 3;

  typedef struct {
    int op;
    int n;
    int emin;
    int esec;
    int ems;
    bit erun;
    bit elap;
    bit eovf;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       uc [3];
  logic       ss [3];
  logic       lc [3];
  logic [6:0] dmin [3];
  logic [5:0] dsec [3];
  logic [9:0] dms  [3];
  logic       drun [3];
  logic       dlap [3];
  logic       dovf [3];

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [$];

  // 0: main, 1: MIN_MAX=0 for overflow, 2: rising edges only
  mili_stopwatch #(.BOTH_EDGES(1), .MIN_MAX(99)) u_dut (
    .clk(clk), .reset(reset), .usr_clk(uc[0]), .start_stop(ss[0]), .lap_clear(lc[0]),
    .disp_min(dmin[0]), .disp_sec(dsec[0]), .disp_ms(dms[0]),
    .running(drun[0]), .lap_active(dlap[0]), .overflow(dovf[0]));

  mili_stopwatch #(.BOTH_EDGES(1), .MIN_MAX(0)) u_ovf (
    .clk(clk), .reset(reset), .usr_clk(uc[1]), .start_stop(ss[1]), .lap_clear(lc[1]),
    .disp_min(dmin[1]), .disp_sec(dsec[1]), .disp_ms(dms[1]),
    .running(drun[1]), .lap_active(dlap[1]), .overflow(dovf[1]));

  mili_stopwatch #(.BOTH_EDGES(0), .MIN_MAX(99)) u_rise (
    .clk(clk), .reset(reset), .usr_clk(uc[2]), .start_stop(ss[2]), .lap_clear(lc[2]),
    .disp_min(dmin[2]), .disp_sec(dsec[2]), .disp_ms(dms[2]),
    .running(drun[2]), .lap_active(dlap[2]), .overflow(dovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int idx, input int emin, input int esec,
                           input int ems, input bit er, input bit el, input bit eo);
    chk({tag, ".min"}, int'(dmin[idx]), emin);
    chk({tag, ".sec"}, int'(dsec[idx]), esec);
    chk({tag, ".ms"},  int'(dms[idx]),  ems);
    chk({tag, ".running"},    int'(drun[idx]), int'(er));
    chk({tag, ".lap_active"}, int'(dlap[idx]), int'(el));
    chk({tag, ".overflow"},   int'(dovf[idx]), int'(eo));
  endtask

  task automatic ticks(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      uc[idx] = ~uc[idx];
      step();
    end
    step();
    step();
  endtask

  task automatic pulse(input int idx, input bit s, input bit l);
    ss[idx] = s;
    lc[idx] = l;
    step();
    ss[idx] = 1'b0;
    lc[idx] = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    case (vecs[i].op)
      OP_TICKS: ticks(0, vecs[i].n);
      OP_SS:    pulse(0, 1'b1, 1'b0);
      OP_LC:    pulse(0, 1'b0, 1'b1);
      default:  pulse(0, 1'b1, 1'b1);
    endcase
    check_dut($sformatf("vec%0d", i), 0, vecs[i].emin, vecs[i].esec, vecs[i].ems,
              vecs[i].erun, vecs[i].elap, vecs[i].eovf);
  endtask

  initial begin
    vecs.push_back('{OP_TICKS, 10,    0, 0, 0,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SS,    0,     0, 0, 0,   1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_TICKS, 999,   0, 1, 0,   1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_TICKS, 1500,  0, 2, 500, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_LC,    0,     0, 2, 500, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{OP_TICKS, 300,   0, 2, 500, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{OP_LC,    0,     0, 2, 800, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_SS,    0,     0, 2, 800, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_TICKS, 20,    0, 2, 800, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_LC,    0,     0, 0, 0,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SS,    0,     0, 0, 0,   1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_TICKS, 50,    0, 0, 50,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_SS,    0,     0, 0, 50,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_TICKS, 20,    0, 0, 50,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_LC,    0,     0, 0, 0,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SS,    0,     0, 0, 0,   1'b1, 1'b0, 1'b0});
    vecs.push_back('{OP_BOTH,  0,     0, 0, 0,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{OP_SS,    0,     0, 0, 0,   1'b1, 1'b0, 1'b0});

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      uc[i] = 1'b0;
      ss[i] = 1'b0;
      lc[i] = 1'b0;
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) check_dut($sformatf("reset%0d", i), i, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 2; i++) apply_vec(i);

    uc[0] = ~uc[0];
    step();
    chk("latency.edge_k", int'(dms[0]), 0);
    step();
    chk("latency.edge_k1", int'(dms[0]), 0);
    step();
    chk("latency.edge_k2", int'(dms[0]), 1);

    for (int i = 2; i < vecs.size(); i++) apply_vec(i);

    pulse(1, 1'b1, 1'b0);
    check_dut("ovf.start", 1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 59998; k++) begin
      uc[0] = ~uc[0];
      uc[1] = ~uc[1];
      step();
    end
    step();
    step();
    check_dut("ovf.preload", 1, 0, 59, 998, 1'b1, 1'b0, 1'b0);
    check_dut("main.preload", 0, 0, 59, 998, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      uc[0] = ~uc[0];
      uc[1] = ~uc[1];
      step();
    end
    step();
    step();
    check_dut("ovf.saturate", 1, 0, 59, 999, 1'b0, 1'b0, 1'b1);
    check_dut("main.mincarry", 0, 1, 0, 1, 1'b1, 1'b0, 1'b0);
    pulse(1, 1'b1, 1'b0);
    check_dut("ovf.ss_held", 1, 0, 59, 999, 1'b0, 1'b0, 1'b1);
    pulse(1, 1'b0, 1'b1);
    check_dut("ovf.clear", 1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    pulse(1, 1'b1, 1'b0);
    check_dut("ovf.restart", 1, 0, 0, 0, 1'b1, 1'b0, 1'b0);

    pulse(2, 1'b1, 1'b0);
    ticks(2, 20);
    check_dut("rise.10periods", 2, 0, 0, 10, 1'b1, 1'b0, 1'b0);

    #3 reset = 1'b0;
    #1;
    check_dut("async_reset", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("async_reset.rise_ms", int'(dms[2]), 0);
    step();
    reset = 1'b1;
    ticks(0, 4);
    check_dut("post_reset_idle", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
